// File: rtl/board_test_button_pkg.sv
// Shared types and default timing constants for the board-test button conditioner.
package board_test_button_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 65536;
   localparam int unsigned DEF_LONG_CYCLES     = 2621440;

endpackage

// File: rtl/board_test_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold counter and registered pulses.
module board_test_debounce_channel
   import board_test_button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic int_clock,
   input  logic rst,
   input  logic btn_n_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] DEB_ONE   = DW'(1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   btn_state_t    state_q, state_d;
   logic          sync1_q, sync_q;
   logic [DW-1:0] deb_q, deb_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          rel_q, rel_d;
   logic          long_q, long_d;
   logic          hold_run;

   always_ff @(posedge int_clock or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync_q  <= 1'b1;
         state_q <= IDLE;
         deb_q   <= '0;
         hold_q  <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         sync1_q <= btn_n_i;
         sync_q  <= sync1_q;
         state_q <= state_d;
         deb_q   <= deb_d;
         hold_q  <= hold_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         long_q  <= long_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      deb_d    = deb_q;
      hold_d   = hold_q;
      level_d  = level_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      hold_run = (state_q == PRESSED || state_q == RELEASE_WAIT) && (hold_q != HOLD_MAX);
      if (hold_run) hold_d = hold_q + HW'(1);

      unique case (state_q)
         IDLE: begin
            if (!sync_q) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = PRESSED;
                  level_d = 1'b1;
                  press_d = 1'b1;
                  deb_d   = '0;
                  hold_d  = '0;
               end else begin
                  state_d = PRESS_WAIT;
                  deb_d   = DEB_ONE;
               end
            end
         end
         PRESS_WAIT: begin
            if (sync_q) begin
               state_d = IDLE;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d = PRESSED;
               level_d = 1'b1;
               press_d = 1'b1;
               deb_d   = '0;
               hold_d  = '0;
            end else begin
               deb_d = deb_q + DEB_ONE;
            end
         end
         PRESSED: begin
            if (sync_q) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = IDLE;
                  level_d = 1'b0;
                  rel_d   = 1'b1;
                  deb_d   = '0;
               end else begin
                  state_d = RELEASE_WAIT;
                  deb_d   = DEB_ONE;
               end
            end
         end
         RELEASE_WAIT: begin
            if (!sync_q) begin
               state_d = PRESSED;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d = IDLE;
               level_d = 1'b0;
               rel_d   = 1'b1;
               deb_d   = '0;
            end else begin
               deb_d = deb_q + DEB_ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A release committing on the same edge suppresses the long pulse.
      long_d = hold_run && (hold_q == HOLD_LAST) && !rel_d;
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;
   assign long_o    = long_q;

endmodule

// File: rtl/board_test_button_conditioner.sv
// Conditions the S1/S2 push buttons into debounced levels and one-cycle event pulses.
module board_test_button_conditioner
   import board_test_button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic int_clock,
   input  logic rst,
   input  logic s1_n,
   input  logic s2_n,
   output logic s1_level,
   output logic s2_level,
   output logic s1_press,
   output logic s2_press,
   output logic s1_release,
   output logic s2_release,
   output logic s1_long,
   output logic s2_long,
   output logic both_held
);

   board_test_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
   ) u_s1 (
      .int_clock(int_clock),
      .rst      (rst),
      .btn_n_i  (s1_n),
      .level_o  (s1_level),
      .press_o  (s1_press),
      .release_o(s1_release),
      .long_o   (s1_long)
   );

   board_test_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
   ) u_s2 (
      .int_clock(int_clock),
      .rst      (rst),
      .btn_n_i  (s2_n),
      .level_o  (s2_level),
      .press_o  (s2_press),
      .release_o(s2_release),
      .long_o   (s2_long)
   );

   assign both_held = s1_level & s2_level;

endmodule

// File: tb/tb_board_test_button_conditioner.sv
// Directed bench for the button conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_board_test_button_conditioner;

   logic int_clock = 1'b0;
   logic rst  = 1'b0;
   logic s1_n = 1'b1;
   logic s2_n = 1'b1;
   logic s1_level, s2_level, s1_press, s2_press;
   logic s1_release, s2_release, s1_long, s2_long, both_held;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;
   int np1 = 0, np2 = 0, nr1 = 0, nr2 = 0, nl1 = 0, nl2 = 0;
   int p2_edge = 0, l2_edge = 0;
   int base_r1;
   logic [8:0] outs;

   board_test_button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES    (20)
   ) dut (
      .int_clock (int_clock),
      .rst       (rst),
      .s1_n      (s1_n),
      .s2_n      (s2_n),
      .s1_level  (s1_level),
      .s2_level  (s2_level),
      .s1_press  (s1_press),
      .s2_press  (s2_press),
      .s1_release(s1_release),
      .s2_release(s2_release),
      .s1_long   (s1_long),
      .s2_long   (s2_long),
      .both_held (both_held)
   );

   always #5 int_clock = ~int_clock;

   assign outs = {s1_level, s2_level, s1_press, s2_press, s1_release,
                  s2_release, s1_long, s2_long, both_held};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance n edges, sampling 1 time unit after each and tallying pulses.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge int_clock);
         #1;
         edge_n++;
         if (s1_press)   np1++;
         if (s2_press)   begin np2++; p2_edge = edge_n; end
         if (s1_release) nr1++;
         if (s2_release) nr2++;
         if (s1_long)    nl1++;
         if (s2_long)    begin nl2++; l2_edge = edge_n; end
      end
   endtask

   initial begin
      step(3);
      chk("reset_outs", 32'(outs), 32'h0);
      rst = 1'b1;
      step(3);
      chk("idle_outs", 32'(outs), 32'h0);

      // Clean S1 press
      s1_n = 1'b0;
      step(5);
      chk("clean_no_early_press", 32'(s1_press), 32'h0);
      step(1);
      chk("clean_press_edge6", 32'(s1_press), 32'h1);
      chk("clean_level", 32'(s1_level), 32'h1);
      step(1);
      chk("clean_press_one_cycle", 32'(s1_press), 32'h0);
      chk("clean_s2_quiet", 32'({s2_level, s2_press, s2_release, s2_long}), 32'h0);

      // Release with a one-edge glitch
      s1_n = 1'b1; step(2);
      s1_n = 1'b0; step(1);
      s1_n = 1'b1;
      step(5);
      chk("rel_no_early_release", 32'(nr1), 32'h0);
      step(1);
      chk("rel_pulse_edge6", 32'(s1_release), 32'h1);
      chk("rel_level_low", 32'(s1_level), 32'h0);
      step(5);
      chk("rel_single_pulse", 32'(nr1), 32'h1);
      chk("rel_no_long", 32'(nl1), 32'h0);

      // Bounce: low 3, high 1, low 8
      s1_n = 1'b0; step(3);
      s1_n = 1'b1; step(1);
      s1_n = 1'b0;
      step(5);
      chk("bounce_no_press_yet", 32'(np1), 32'h1);
      step(1);
      chk("bounce_press_edge6", 32'(s1_press), 32'h1);
      step(2);
      chk("bounce_single_press", 32'(np1), 32'h2);
      s1_n = 1'b1;
      step(8);
      chk("bounce_released", 32'({s1_level, 5'(nr1)}), 32'h02);

      // Long press on S2
      s2_n = 1'b0;
      step(40);
      chk("long_press_count", 32'(np2), 32'h1);
      chk("long_count", 32'(nl2), 32'h1);
      chk("long_delay", 32'(l2_edge - p2_edge), 32'd20);
      chk("long_no_release_yet", 32'(nr2), 32'h0);
      s2_n = 1'b1;
      step(5);
      chk("long_rel_not_early", 32'(nr2), 32'h0);
      step(1);
      chk("long_rel_edge6", 32'(s2_release), 32'h1);
      step(2);
      chk("long_still_single", 32'(nl2), 32'h1);
      chk("long_s1_untouched", 32'({5'(np1), 5'(nl1)}), 32'({5'd2, 5'd0}));

      // Both buttons together
      s1_n = 1'b0; s2_n = 1'b0;
      step(6);
      chk("both_press_coincide", 32'({s1_press, s2_press}), 32'h3);
      chk("both_held_set", 32'(both_held), 32'h1);
      s1_n = 1'b1;
      step(5);
      chk("both_held_before_rel", 32'(both_held), 32'h1);
      step(1);
      chk("both_s1_release", 32'(s1_release), 32'h1);
      chk("both_held_cleared", 32'(both_held), 32'h0);
      s2_n = 1'b1;
      step(30);

      // Async reset while S1 is held
      s1_n = 1'b0;
      step(8);
      chk("rst_pre_level", 32'(s1_level), 32'h1);
      base_r1 = nr1;
      rst = 1'b0;
      #1;
      chk("rst_async_clear", 32'(outs), 32'h0);
      step(3);
      chk("rst_no_release", 32'(nr1 - base_r1), 32'h0);
      rst = 1'b1;
      step(5);
      chk("rst_no_early_press", 32'(s1_press), 32'h0);
      step(1);
      chk("rst_repress_edge6", 32'(s1_press), 32'h1);
      chk("rst_repress_level", 32'(s1_level), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/board_test_button_conditioner.md
Name: board_test_button_conditioner

Overview:
- Conditions the two raw on-board push buttons (S1, S2) of the Tang Nano 9K board-test design before they reach the LED blinker stage.
- Per button: 2-flop synchroniser, debounce FSM, one-cycle press/release/long-press pulses and a stable level.
- Also provides a combined both-held level. The blinker consumes the pulses and levels, never the raw pins.

Parameters:
- DEBOUNCE_CYCLES, 65536, consecutive stable samples required to accept a press or release; legal range 1..2^24.
- LONG_CYCLES, 2621440, pressed samples after an accepted press before long-press fires (~1 s at 2.62 MHz); must be >= 1.

Ports:
- int_clock  input  1  internal oscillator clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- s1_n  input  1  raw S1 pin; 0 = pressed; asynchronous, bouncing.
- s2_n  input  1  raw S2 pin; same as s1_n.
- s1_level  output  1  debounced S1 state; 1 = pressed.
- s2_level  output  1  debounced S2 state.
- s1_press  output  1  one-cycle pulse on accepted S1 press.
- s2_press  output  1  one-cycle pulse on accepted S2 press.
- s1_release  output  1  one-cycle pulse on accepted S1 release.
- s2_release  output  1  one-cycle pulse on accepted S2 release.
- s1_long  output  1  one-cycle pulse when S1 has been held LONG_CYCLES.
- s2_long  output  1  one-cycle pulse for S2.
- both_held  output  1  s1_level AND s2_level (combinational from registered levels).

Behaviour:
- Reset (rst=0, async assert, sync-free release):
  - Synchroniser flops load 1 (released).
  - FSM goes to IDLE; both counters 0.
  - All outputs 0, including both_held.
- Synchroniser: two flops per button; the FSM samples only the second flop (sync). Raw-to-sync latency is 2 edges.
- FSM per channel, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: sync=0 -> PRESS_WAIT with deb_cnt=1; else stay.
  - PRESS_WAIT: sync=1 -> IDLE, deb_cnt=0 (glitch rejected, no pulse). sync=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED, level<=1, press pulse, deb_cnt=0, hold_cnt=0. Otherwise deb_cnt++.
  - PRESSED: sync=1 -> RELEASE_WAIT, deb_cnt=1. hold_cnt increments every edge while in PRESSED or RELEASE_WAIT; saturates at LONG_CYCLES.
  - RELEASE_WAIT: sync=0 -> PRESSED, deb_cnt=0 (release glitch). sync=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE, level<=0, release pulse. Otherwise deb_cnt++.
  - DEBOUNCE_CYCLES=1: transition on the same edge as entry; the WAIT state is skipped (IDLE->PRESSED direct).
- Latency: press pulse and level rise registered DEBOUNCE_CYCLES+2 edges after the first edge sampling raw=0, provided raw stays 0. Release is symmetric.
- Long press:
  - Long pulse fires on the edge where hold_cnt reaches LONG_CYCLES; at most once per accepted press.
  - Never fires after the release commits.
  - If the release commits on the same edge hold_cnt reaches LONG_CYCLES, release wins and there is no long pulse.
- Pulses are exactly one cycle, registered, and never overlap within a channel. Press and long never share a cycle because LONG_CYCLES >= 1.
- The two channels are fully independent; simultaneous events on both channels are legal.
- Reset mid-operation: immediate return to reset values. No release pulse is generated for a button held across reset; the press is re-debounced after reset.
- Counter widths: $clog2(max+1) of the respective parameter. No wrap: both counters are bounded by the FSM.

Decomposition:
- Package board_test_button_pkg:
  - btn_state_t enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - Default parameter constants.
- Sub-module board_test_debounce_channel: one synchroniser, FSM and counters; instantiated twice. The top adds only both_held.

Test Plan (sim with DEBOUNCE_CYCLES=4, LONG_CYCLES=20):
- Clean press: s1_n 1->0 held -> s1_press high exactly 1 cycle at edge 6 after the first low sample; s1_level=1; s2 outputs stay 0.
- Bounce: s1_n low 3 edges, high 1, low 8 -> no pulse from the first burst; s1_press at edge 6 of the final low run.
- Release with glitch: from pressed, s1_n high 2, low 1, high 10 -> one s1_release 6 edges into the final high run; s1_level=0 after it.
- Long press: s2_n held low 40 edges -> s2_press, then s2_long exactly 20 edges later, single pulse; s2_release only after s2_n goes high + 6 edges.
- Both buttons: both pressed same cycle -> s1_press and s2_press coincide, both_held=1; releasing S1 -> both_held=0 with s1_release.
- Async reset while held: rst=0 mid-PRESSED -> all outputs 0 immediately with no release pulse; after rst=1 with s1_n still low, s1_press re-fires 6 edges later.
